ram_port_ctrl: RTL and testbench
================================

Name: ram_port_ctrl

Overview:
- Request sequencer that sits directly upstream of the single-port synchronous RAM (port A) and owns its address, write-data and write-enable pins.
- Accepts in-order read/write requests over a valid/ready interface and issues at most one RAM access per cycle.
- Captures RAM read data exactly one cycle after issue into a small response FIFO. Read data is returned over a valid/ready response interface with backpressure, using credit-based flow control so no read data is ever lost.

Parameters:
- DATAWIDTH, 8, RAM word width; must match the attached RAM.
- ADDRWIDTH, 4, RAM address width; RAM depth is 2**ADDRWIDTH.
- RSP_DEPTH, 4, response FIFO entries; minimum 2.

Ports:
- PortAClk  input  1  clock; shared with the RAM.
- PortAReset  input  1  reset; synchronous, active-high.
- ReqValid  input  1  request valid.
- ReqReady  output  1  request accepted when ReqValid && ReqReady.
- ReqWrite  input  1  1 = write, 0 = read.
- ReqAddr  input  ADDRWIDTH  request address.
- ReqWData  input  DATAWIDTH  write data; ignored for reads.
- RspValid  output  1  read data valid.
- RspReady  input  1  consumer accepts read data.
- RspData  output  DATAWIDTH  read data, in request order.
- RamAddr  output  ADDRWIDTH  to RAM PortAAddr.
- RamDataIn  output  DATAWIDTH  to RAM PortADataIn.
- RamWriteEnable  output  1  to RAM PortAWriteEnable.
- RamDataOut  input  DATAWIDTH  from RAM PortADataOut; registered, 1-cycle latency.
- InitDone  output  1  controller is in RUN state.

Behaviour:
- Clock and reset: one clock, PortAClk. Reset is synchronous and active-high (PortAReset).
- States:
  - INIT: present only with the optional feature.
  - RUN.
  - On reset, the FSM goes to INIT if the feature is compiled in, otherwise to RUN.
- Reset values:
  - RspValid = 0, InitDone = 0, RamWriteEnable = 0, ReqReady = 0.
  - FIFO count = 0, in-flight flag = 0.
  - RAM contents are not touched by reset itself.
- Credit rule: ReqReady = RUN && (inflight + fifo_count) < RSP_DEPTH.
  - Uses registered values only; a same-cycle FIFO pop frees its credit in the next cycle.
  - ReqReady does not depend on ReqValid or ReqWrite.
- Issue, combinational in the accept cycle N:
  - RamAddr = ReqAddr, RamDataIn = ReqWData.
  - RamWriteEnable = accept && ReqWrite.
  - When not accepting, RamWriteEnable = 0 and RamAddr is don't-care. Stray RAM reads are harmless because their data is never captured.
- Reads:
  - An accepted read sets inflight for cycle N+1.
  - In cycle N+1 RamDataOut is pushed into the FIFO, and RspValid is asserted from cycle N+2 at the earliest.
- Writes:
  - An accepted write produces no response.
  - A write at N followed by a read of the same address at N+1 returns the new data (RAM is in-order).
- FIFO:
  - RspValid = (fifo_count != 0); RspData = head entry.
  - Pop on RspValid && RspReady.
  - Simultaneous push and pop keeps the count unchanged.
  - Overflow is impossible by the credit rule; an overflow is an assertion failure.
- Reset mid-operation: FIFO contents and any in-flight read are discarded; RspValid = 0 in the cycle after reset is sampled.

Optional Feature:
- Macro: RAM_PORT_CTRL_INIT_ZERO_EN.
- Defined:
  - After reset the FSM is in INIT, and a counter sweeps addresses 0 .. 2**ADDRWIDTH-1 with RamWriteEnable = 1 and RamDataIn = 0, one address per cycle.
  - ReqReady = 0 and InitDone = 0 throughout the sweep.
  - After the last address the FSM enters RUN and InitDone = 1.
  - Reset during INIT restarts the sweep at address 0.
- Not defined:
  - No INIT state and no counter; the FSM enters RUN the cycle after reset deasserts.
  - InitDone = 1 from that cycle on.

Decomposition:
- Shared package ram_port_ctrl_pkg: FSM state encoding (INIT, RUN) and a localparam helper for the count width, clog2(RSP_DEPTH+1).
- One sub-module, ram_port_ctrl_rsp_fifo: synchronous FIFO, parameterised width/depth, with push, pop, count, head data and the same reset.

Test Plan:
- Write addr 3 data 8'hA5, then read addr 3 with RspReady=1 -> RspValid rises 2 cycles after read accept, RspData = 8'hA5.
- Write addr 5 = 8'h11 at cycle N, read addr 5 at N+1 -> response 8'h11 (no stale data).
- RspReady=0, offer 6 reads of addrs 0..5 -> exactly 4 accepted, ReqReady = 0 afterwards. Raise RspReady -> 4 responses in order, then the remaining reads are accepted.
- RspReady=1, 16 back-to-back reads -> ReqReady never drops, 16 in-order responses at 1 per cycle.
- Two responses buffered plus one in flight, pulse PortAReset -> RspValid = 0 next cycle, no stale response after reset.
- With RAM_PORT_CTRL_INIT_ZERO_EN, ADDRWIDTH=4 -> InitDone rises 16 cycles after reset release; a read of any previously written address then returns 8'h00.

Source files
------------

// File: rtl/ram_port_ctrl_pkg.sv
// Shared definitions for the RAM port-A request sequencer.
// Holds the FSM state encoding and the response-count width helper.
package ram_port_ctrl_pkg;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Counter width that can represent 0..depth inclusive.
    function automatic int rsp_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ram_port_ctrl_rsp_fifo.sv
// Response FIFO for captured RAM read data.
// Synchronous active-high reset clears pointers and count; storage is not reset.
module ram_port_ctrl_rsp_fifo
    import ram_port_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = rsp_cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_pop;

    // A pop on an empty FIFO is ignored rather than corrupting the count.
    assign do_pop    = pop && (count_q != '0);
    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Data storage; contents are meaningless until written, so no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // The upstream credit check must make a push into a full FIFO impossible.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !do_pop && (count_q == CNT_W'(DEPTH))));

endmodule

// File: rtl/ram_port_ctrl.sv
// Request sequencer in front of a single-port synchronous RAM (port A).
// Optional build macro RAM_PORT_CTRL_INIT_ZERO_EN: zero-fill the RAM after reset.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_INIT | zero-fill sweep, one address per cycle (only with macro)
// ST_RUN  | accepting requests, subject to response credits
module ram_port_ctrl
    import ram_port_ctrl_pkg::*;
#(
    parameter int DATAWIDTH = 8,
    parameter int ADDRWIDTH = 4,
    parameter int RSP_DEPTH = 4
) (
    input  logic                 PortAClk,
    input  logic                 PortAReset,
    input  logic                 ReqValid,
    output logic                 ReqReady,
    input  logic                 ReqWrite,
    input  logic [ADDRWIDTH-1:0] ReqAddr,
    input  logic [DATAWIDTH-1:0] ReqWData,
    output logic                 RspValid,
    input  logic                 RspReady,
    output logic [DATAWIDTH-1:0] RspData,
    output logic [ADDRWIDTH-1:0] RamAddr,
    output logic [DATAWIDTH-1:0] RamDataIn,
    output logic                 RamWriteEnable,
    input  logic [DATAWIDTH-1:0] RamDataOut,
    output logic                 InitDone
);

    localparam int CNT_W = rsp_cnt_w(RSP_DEPTH);
    localparam int CRD_W = CNT_W + 1;

    state_e               state_q, state_d;
    logic                 init_done_q, init_done_d;
    logic                 inflight_q, inflight_d;
`ifdef RAM_PORT_CTRL_INIT_ZERO_EN
    logic [ADDRWIDTH-1:0] sweep_q, sweep_d;
`endif
    logic [CNT_W-1:0]     fifo_count;
    logic [CRD_W-1:0]     credits_used;
    logic                 accept;
    logic                 rsp_pop;

    // A credit is held from read accept until its response is popped.
    assign credits_used = CRD_W'(fifo_count) + CRD_W'(inflight_q);
    assign ReqReady     = (state_q == ST_RUN) && init_done_q
                          && (credits_used < CRD_W'(RSP_DEPTH));
    assign accept       = ReqValid && ReqReady;
    assign rsp_pop      = RspValid && RspReady;
    assign RspValid     = (fifo_count != '0);
    assign InitDone     = init_done_q;
    assign inflight_d   = accept && !ReqWrite;

    // RAM pin drive: the sweep owns the port in INIT, requests own it in RUN.
    // Writes are suppressed while reset is asserted so reset never disturbs RAM.
    always_comb begin
        RamAddr        = ReqAddr;
        RamDataIn      = ReqWData;
        RamWriteEnable = accept && ReqWrite && !PortAReset;
`ifdef RAM_PORT_CTRL_INIT_ZERO_EN
        if (state_q == ST_INIT) begin
            RamAddr        = sweep_q;
            RamDataIn      = '0;
            RamWriteEnable = !PortAReset;
        end
`endif
    end

    // FSM next-state and sweep address.
    always_comb begin
        state_d     = state_q;
        init_done_d = init_done_q;
`ifdef RAM_PORT_CTRL_INIT_ZERO_EN
        sweep_d     = sweep_q;
        if (state_q == ST_INIT) begin
            sweep_d = sweep_q + 1'b1;
            if (sweep_q == '1) begin
                state_d     = ST_RUN;
                init_done_d = 1'b1;
            end
        end
`else
        state_d     = ST_RUN;
        init_done_d = 1'b1;
`endif
    end

    // FSM, init-done and in-flight registers with synchronous reset.
    always_ff @(posedge PortAClk) begin
        if (PortAReset) begin
`ifdef RAM_PORT_CTRL_INIT_ZERO_EN
            state_q     <= ST_INIT;
            sweep_q     <= '0;
`else
            state_q     <= ST_RUN;
`endif
            init_done_q <= 1'b0;
            inflight_q  <= 1'b0;
        end else begin
`ifdef RAM_PORT_CTRL_INIT_ZERO_EN
            sweep_q     <= sweep_d;
`endif
            state_q     <= state_d;
            init_done_q <= init_done_d;
            inflight_q  <= inflight_d;
        end
    end

    // RAM output is valid exactly one cycle after a read issue.
    ram_port_ctrl_rsp_fifo #(
        .WIDTH (DATAWIDTH),
        .DEPTH (RSP_DEPTH),
        .CNT_W (CNT_W)
    ) u_rsp_fifo (
        .clk       (PortAClk),
        .rst       (PortAReset),
        .push      (inflight_q),
        .push_data (RamDataOut),
        .pop       (rsp_pop),
        .head_data (RspData),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_ram_port_ctrl.sv
// Directed bench for ram_port_ctrl with a behavioural port-A RAM.
// Covers both builds; RAM_PORT_CTRL_INIT_ZERO_EN changes expected RAM contents.
module tb_ram_port_ctrl;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int RD = 4;
`ifdef RAM_PORT_CTRL_INIT_ZERO_EN
    localparam int EXP_INIT = 1 << AW;
`else
    localparam int EXP_INIT = 1;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          ReqValid, ReqReady, ReqWrite;
    logic [AW-1:0] ReqAddr;
    logic [DW-1:0] ReqWData;
    logic          RspValid, RspReady;
    logic [DW-1:0] RspData;
    logic [AW-1:0] RamAddr;
    logic [DW-1:0] RamDataIn;
    logic          RamWriteEnable;
    logic [DW-1:0] RamDataOut;
    logic          InitDone;
    logic          preload;

    logic [DW-1:0] ram_mem [2**AW];
    logic [DW-1:0] exp_mem [2**AW];
    logic [DW-1:0] got [$];
    int            got_cyc [$];
    int            total = 0;
    int            bad = 0;
    int            cyc = 0;

    ram_port_ctrl #(.DATAWIDTH(DW), .ADDRWIDTH(AW), .RSP_DEPTH(RD)) dut (
        .PortAClk       (clk),
        .PortAReset     (rst),
        .ReqValid       (ReqValid),
        .ReqReady       (ReqReady),
        .ReqWrite       (ReqWrite),
        .ReqAddr        (ReqAddr),
        .ReqWData       (ReqWData),
        .RspValid       (RspValid),
        .RspReady       (RspReady),
        .RspData        (RspData),
        .RamAddr        (RamAddr),
        .RamDataIn      (RamDataIn),
        .RamWriteEnable (RamWriteEnable),
        .RamDataOut     (RamDataOut),
        .InitDone       (InitDone)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Single-port RAM, registered read, read-before-write.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 2**AW; i++) ram_mem[i] <= DW'(8'h40 + i);
        end else if (RamWriteEnable) begin
            ram_mem[RamAddr] <= RamDataIn;
        end
        RamDataOut <= ram_mem[RamAddr];
    end

    // Record every response handshake.
    always @(posedge clk) begin
        if (!rst && RspValid && RspReady) begin
            got.push_back(RspData);
            got_cyc.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic got_at(input int idx, output logic [31:0] val);
        val = (got.size() > idx) ? 32'(got[idx]) : 32'hDEAD_BEEF;
    endtask

    // Wait for InitDone; counts cycles, early ReqReady and sweep mistakes.
    task automatic wait_init(output int n, output int rr, output int sw);
        int i;
        i = 0; rr = 0; sw = 0;
        while (!InitDone && i < 40) begin
            if (ReqReady) rr++;
`ifdef RAM_PORT_CTRL_INIT_ZERO_EN
            if (!(RamWriteEnable && RamAddr == i[AW-1:0] && RamDataIn == '0)) sw++;
`endif
            tick();
            i++;
        end
        n = i;
    endtask

    initial begin
        int n, rr, sw, acc, base, drops;
        logic [31:0] v;

        rst = 1'b1; preload = 1'b1; RspReady = 1'b1;
        ReqValid = 1'b0; ReqWrite = 1'b0; ReqAddr = '0; ReqWData = '0;
        for (int i = 0; i < 2**AW; i++) exp_mem[i] = DW'(8'h40 + i);
        tick();
        preload = 1'b0;
        tick();
        check("rst_rsp_valid", 32'(RspValid), 0);
        check("rst_req_ready", 32'(ReqReady), 0);
        check("rst_init_done", 32'(InitDone), 0);
        check("rst_we", 32'(RamWriteEnable), 0);

        rst = 1'b0;
        wait_init(n, rr, sw);
        check("init_latency", 32'(n), EXP_INIT);
        check("init_ready_low", 32'(rr), 0);
        check("init_sweep", 32'(sw), 0);
`ifdef RAM_PORT_CTRL_INIT_ZERO_EN
        for (int i = 0; i < 2**AW; i++) exp_mem[i] = '0;
`endif

        // Write then read the same address.
        ReqValid = 1'b1; ReqWrite = 1'b1; ReqAddr = 4'd3; ReqWData = 8'hA5;
        #1;
        check("t1_ready", 32'(ReqReady), 1);
        check("t1_we", 32'(RamWriteEnable), 1);
        check("t1_addr", 32'(RamAddr), 3);
        check("t1_wdata", 32'(RamDataIn), 32'hA5);
        tick();
        exp_mem[3] = 8'hA5;
        ReqWrite = 1'b0;
        #1;
        check("t1_rd_we", 32'(RamWriteEnable), 0);
        tick();
        ReqValid = 1'b0;
        check("t1_n1_valid", 32'(RspValid), 0);
        tick();
        check("t1_n2_valid", 32'(RspValid), 1);
        check("t1_data", 32'(RspData), 32'hA5);
        tick();
        check("t1_drain", 32'(RspValid), 0);

        // Back-to-back write/read of address 5.
        ReqValid = 1'b1; ReqWrite = 1'b1; ReqAddr = 4'd5; ReqWData = 8'h11;
        tick();
        exp_mem[5] = 8'h11;
        ReqWrite = 1'b0;
        tick();
        ReqValid = 1'b0;
        tick();
        check("t2_valid", 32'(RspValid), 1);
        check("t2_data", 32'(RspData), 32'h11);
        tick();

        // Credit limit with response backpressure.
        RspReady = 1'b0; base = got.size(); acc = 0;
        for (int c = 0; c < 8; c++) begin
            ReqValid = (acc < 6); ReqWrite = 1'b0; ReqAddr = acc[AW-1:0];
            #1;
            if (ReqValid && ReqReady) acc++;
            tick();
        end
        check("t3_accepted", 32'(acc), 4);
        check("t3_ready_low", 32'(ReqReady), 0);
        check("t3_valid", 32'(RspValid), 1);
        check("t3_head", 32'(RspData), 32'(exp_mem[0]));
        check("t3_no_pop", 32'(got.size() - base), 0);
        RspReady = 1'b1; n = 0;
        while (acc < 6 && n < 30) begin
            ReqValid = 1'b1; ReqAddr = acc[AW-1:0];
            #1;
            if (ReqReady) acc++;
            tick();
            n++;
        end
        ReqValid = 1'b0;
        check("t3_rest_accepted", 32'(acc), 6);
        n = 0;
        while (got.size() - base < 6 && n < 30) begin tick(); n++; end
        for (int k = 0; k < 6; k++) begin
            got_at(base + k, v);
            check($sformatf("t3_rsp%0d", k), v, 32'(exp_mem[k]));
        end

        // Sixteen back-to-back reads with no backpressure.
        base = got.size(); drops = 0;
        for (int i = 0; i < 16; i++) begin
            ReqValid = 1'b1; ReqWrite = 1'b0; ReqAddr = AW'(i);
            #1;
            if (!ReqReady) drops++;
            tick();
        end
        ReqValid = 1'b0;
        check("t4_no_stall", 32'(drops), 0);
        n = 0;
        while (got.size() - base < 16 && n < 40) begin tick(); n++; end
        check("t4_count", 32'(got.size() - base), 16);
        for (int k = 0; k < 16; k++) begin
            got_at(base + k, v);
            check($sformatf("t4_rsp%0d", k), v, 32'(exp_mem[k]));
        end
        if (got_cyc.size() >= base + 16)
            check("t4_rate", 32'(got_cyc[base + 15] - got_cyc[base]), 15);
        else
            check("t4_rate", 32'hFFFF_FFFF, 15);

        // Reset with two buffered responses and one read in flight.
        RspReady = 1'b0; base = got.size();
        ReqValid = 1'b1; ReqWrite = 1'b0; ReqAddr = 4'd7;
        tick();
        ReqAddr = 4'd8;
        tick();
        ReqAddr = 4'd9;
        tick();
        ReqValid = 1'b0;
        check("t5_buffered", 32'(RspValid), 1);
        rst = 1'b1;
        #1;
        check("t5_rst_we", 32'(RamWriteEnable), 0);
        tick();
        check("t5_rsp_cleared", 32'(RspValid), 0);
        check("t5_ready", 32'(ReqReady), 0);
        check("t5_init_done", 32'(InitDone), 0);
        rst = 1'b0; RspReady = 1'b1;
        wait_init(n, rr, sw);
        check("t5_init_latency", 32'(n), EXP_INIT);
        check("t5_init_ready_low", 32'(rr), 0);
        check("t5_init_sweep", 32'(sw), 0);
`ifdef RAM_PORT_CTRL_INIT_ZERO_EN
        for (int i = 0; i < 2**AW; i++) exp_mem[i] = '0;
`endif
        repeat (6) tick();
        check("t5_no_stale", 32'(got.size() - base), 0);
        check("t5_idle_valid", 32'(RspValid), 0);

        // Earlier write survives reset unless the zero-fill sweep ran.
        ReqValid = 1'b1; ReqWrite = 1'b0; ReqAddr = 4'd3;
        tick();
        ReqValid = 1'b0;
        tick();
        check("fin_valid", 32'(RspValid), 1);
        check("fin_data", 32'(RspData), 32'(exp_mem[3]));
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
